// File: rtl/arb_pkg.sv
// Shared definitions for the priority arbiter: FSM state encoding and a
// constant-evaluable ceiling-log2 helper used to size the hold counter.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } arb_state_t;

    // Ceiling log2; returns 0 for values of 0 or 1.
    function automatic int clog2(input int unsigned value);
        int          result;
        int unsigned remain;
        result = 32'sd0;
        if (value > 32'd1) begin
            remain = value - 32'd1;
        end else begin
            remain = 32'd0;
        end
        while (remain > 32'd0) begin
            result = result + 32'sd1;
            remain = remain >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/arbiter_priority_prio_pick.sv
// Combinational rotating priority select.
// Ports:
//   req_n   - active-low request vector, one bit per requester
//   start   - rotation pointer (last winner); search begins one below it
//   rr_en   - 1 = rotate from start, 0 = fixed highest-index-first
//   winner  - index of the selected requester (0 when none)
//   any_req - high when at least one request is active
module prio_pick
    import arb_pkg::*;
#(
    parameter int unsigned SIZE = 3
) (
    input  logic [(1 << SIZE)-1:0] req_n,
    input  logic [SIZE-1:0]        start,
    input  logic                   rr_en,
    output logic [SIZE-1:0]        winner,
    output logic                   any_req
);

    localparam int N = 32'sd1 << SIZE;

    logic [SIZE-1:0] base_s;
    logic [SIZE-1:0] idx_s;

    // Walk base-1, base-2, ... wrapping modulo N; the first active request wins.
    // Fixed priority is the same walk from base 0, i.e. N-1 down to 0.
    always_comb begin
        winner  = '0;
        any_req = 1'b0;
        idx_s   = '0;
        if (rr_en) begin
            base_s = start;
        end else begin
            base_s = '0;
        end
        for (int k = 1; k <= N; k++) begin
            idx_s = base_s - SIZE'(k);
            if (!any_req && !req_n[idx_s]) begin
                winner  = idx_s;
                any_req = 1'b1;
            end else begin
                winner  = winner;
            end
        end
    end

endmodule

// File: rtl/arbiter_priority.sv
// Arbiter granting one shared resource to one of 2**SIZE active-low
// requesters, holding the grant until done, owner withdrawal, or a hold limit.
// Ports:
//   clk, rst_n - rising-edge clock, asynchronous active-low reset
//   req_n      - per-requester request, 0 = requesting
//   done       - owner release pulse, only honoured while granted
//   rr_en      - round-robin (1) or fixed highest-index priority (0)
//   gnt        - one-hot grant
//   gnt_id     - binary owner index, 0 when idle
//   gnt_valid  - high while a grant is held
//   timeout    - one-cycle pulse after a grant is revoked by the hold limit
module arbiter_priority
    import arb_pkg::*;
#(
    parameter int unsigned SIZE     = 3,
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [(1 << SIZE)-1:0] req_n,
    input  logic                   done,
    input  logic                   rr_en,
    output logic [(1 << SIZE)-1:0] gnt,
    output logic [SIZE-1:0]        gnt_id,
    output logic                   gnt_valid,
    output logic                   timeout
);

    localparam int unsigned N  = 32'd1 << SIZE;
    localparam int          CW = clog2(MAX_HOLD) + 32'sd1;

    localparam logic [N-1:0]  GNT_ONE  = {{(N-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_HOLD - 32'd1);

    arb_state_t      state_r,     state_s;
    logic [N-1:0]    gnt_r,       gnt_s;
    logic [SIZE-1:0] gnt_id_r,    gnt_id_s;
    logic            gnt_valid_r, gnt_valid_s;
    logic            timeout_r,   timeout_s;
    logic [SIZE-1:0] last_r,      last_s;
    logic [CW-1:0]   cnt_r,       cnt_s;

    logic [SIZE-1:0] winner_s;
    logic            any_req_s;
    logic            withdraw_s;
    logic            limit_s;

    prio_pick #(
        .SIZE (SIZE)
    ) u_pick (
        .req_n   (req_n),
        .start   (last_r),
        .rr_en   (rr_en),
        .winner  (winner_s),
        .any_req (any_req_s)
    );

    assign withdraw_s = req_n[gnt_id_r];
    assign limit_s    = (cnt_r == CNT_LAST);

    // Next-state, counter, pointer and output computation.
    always_comb begin
        state_s     = state_r;
        gnt_s       = gnt_r;
        gnt_id_s    = gnt_id_r;
        gnt_valid_s = gnt_valid_r;
        timeout_s   = 1'b0;
        last_s      = last_r;
        cnt_s       = cnt_r;
        case (state_r)
            IDLE: begin
                if (any_req_s) begin
                    state_s     = GRANT;
                    gnt_s       = GNT_ONE << winner_s;
                    gnt_id_s    = winner_s;
                    gnt_valid_s = 1'b1;
                    cnt_s       = '0;
                    last_s      = winner_s;
                end else begin
                    state_s = IDLE;
                end
            end
            GRANT: begin
                if (done || withdraw_s || limit_s) begin
                    state_s     = GAP;
                    gnt_s       = '0;
                    gnt_id_s    = '0;
                    gnt_valid_s = 1'b0;
                    cnt_s       = '0;
                    // Only a release caused by the limit alone is a timeout.
                    timeout_s   = limit_s && !done && !withdraw_s;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            GAP: begin
                state_s = IDLE;
            end
            default: begin
                state_s     = IDLE;
                gnt_s       = '0;
                gnt_id_s    = '0;
                gnt_valid_s = 1'b0;
                cnt_s       = '0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            gnt_r       <= '0;
            gnt_id_r    <= '0;
            gnt_valid_r <= 1'b0;
            timeout_r   <= 1'b0;
            last_r      <= '0;
            cnt_r       <= '0;
        end else begin
            state_r     <= state_s;
            gnt_r       <= gnt_s;
            gnt_id_r    <= gnt_id_s;
            gnt_valid_r <= gnt_valid_s;
            timeout_r   <= timeout_s;
            last_r      <= last_s;
            cnt_r       <= cnt_s;
        end
    end

    assign gnt       = gnt_r;
    assign gnt_id    = gnt_id_r;
    assign gnt_valid = gnt_valid_r;
    assign timeout   = timeout_r;

endmodule

// File: doc/arbiter_priority.md
# arbiter_priority

Grants exclusive use of one shared resource to one of 2**SIZE requesters and holds the grant until the owner releases it or a hold timeout expires. Requests are active-low. In fixed mode the highest index wins, the same ordering the priority-encoder datapath uses. In round-robin mode the winner rotates so that no requester starves. The block sits between the requester bank and the shared resource and drives a one-hot grant plus a binary owner index.

## Interface
- SIZE, 3, log2 of requester count; N = 2**SIZE requesters
- MAX_HOLD, 16, maximum cycles a grant may be held; legal range 2..2**16
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req_n  input  N  request per requester, active-low (0 = requesting)
- done  input  1  owner release pulse, active-high, sampled only in GRANT
- rr_en  input  1  1 = round-robin, 0 = fixed priority; sampled at each arbitration
- gnt  output  N  one-hot grant, active-high; all zero when no grant
- gnt_id  output  SIZE  binary index of current owner; 0 when no grant
- gnt_valid  output  1  high while a grant is held
- timeout  output  1  one-cycle pulse when a grant is forcibly revoked

## Operation
- Reset (async, rst_n=0) forces: state IDLE, gnt=0, gnt_id=0, gnt_valid=0, timeout=0, rotation pointer last=0, hold counter=0. This applies mid-grant with no completion.
- All outputs are registered.
- State machine has three states: IDLE, GRANT, GAP.
  - IDLE: if any req_n bit is 0, pick a winner w, then load gnt=1<<w, gnt_id=w, gnt_valid=1, counter=0, last=w, and go to GRANT. Otherwise stay in IDLE.
  - GRANT: the counter increments each cycle. Release occurs when done=1, or req_n[gnt_id]=1 (owner withdrew), or counter==MAX_HOLD-1. On release, clear gnt/gnt_id/gnt_valid and go to GAP.
  - GAP: exactly one cycle with no grant, then go to IDLE. done is ignored.
- Fixed priority (rr_en=0): the active request with the highest index wins.
- Round-robin (rr_en=1): the search order is last-1, last-2, …, 0, N-1, …, last. The first active request in that order wins. With last=0 after reset, the order is N-1..0, which is identical to fixed priority.
- timeout=1 for the single cycle following a release caused solely by the counter limit. If done or owner withdrawal coincides with the limit cycle, the release counts as normal and timeout stays 0.
- done while in IDLE or GAP has no effect. Request changes while in GRANT do not affect the current owner except for withdrawal by the owner itself.
- The counter width is clog2(MAX_HOLD)+1. It never wraps, because release occurs at MAX_HOLD-1.

## Timing
- Request to grant: a request sampled at edge E while in IDLE produces gnt valid after E (1-cycle latency).
- Grant duration: gnt stays high until the edge at which a release is sampled. It is low after that edge.
- Release to next grant: GAP occupies 1 cycle, then the next grant appears after the second edge following release. The minimum is 2 idle-grant cycles between owners.
- Maximum hold is MAX_HOLD cycles of gnt_valid=1.
- timeout is asserted in the GAP cycle only.
- gnt, gnt_id, and gnt_valid always change on the same edge and are mutually consistent.

## Structure
- Shared package arb_pkg holds:
  - state encoding constants IDLE=2'd0, GRANT=2'd1, GAP=2'd2
  - the clog2 helper function
- Sub-module prio_pick is a combinational rotating priority select.
  - Parameter: SIZE.
  - Inputs: active-low request vector, start pointer, rr enable.
  - Outputs: winner index and any-request flag.
  - It uses a loop-based search from high to low index with an early exit.
- The top level contains the FSM, hold counter, rotation pointer, and output registers.

## Test plan
- Reset mid-grant: owner 5 granted, pull rst_n low between edges. All outputs go to 0 immediately without waiting for a clock. After release, a single request from 2 gets gnt=8'h04 after one edge.
- Fixed priority: rr_en=0, req_n=8'b1010_1110 (requesters 6, 4, 0 active). Expect gnt=8'h40 and gnt_id=6 one cycle later. Pulse done, then expect GAP followed by a grant to 6 again.
- Round-robin: rr_en=1, req_n=8'h00 held, done pulsed on each grant's first cycle. Expect grant order 7, 6, 5, 4, 3, 2, 1, 0, 7 with one GAP cycle between each.
- Timeout: only requester 3 requests and done is never pulsed. Expect gnt_valid high for exactly 16 cycles, then timeout=1 with gnt=0 for 1 cycle, then regrant to 3.
- Owner withdrawal: owner 5 sets req_n[5]=1 on grant cycle 4. Expect gnt=0 after that edge, timeout=0, then the next pending requester granted two edges later.
- Coincident release: done=1 on counter cycle 15 (MAX_HOLD-1). Expect a normal release with timeout staying 0.
